// File: rtl/fsm_bin_palin_det.sv
// Serial Moore FSM flagging the non-trivial 3-bit binary palindromes 101 and 010.
// Overlapping windows are reported; 000 and 111 are not.
module fsm_bin_palin_det (
    input  logic ser_in,
    input  logic clk,
    input  logic rst,
    output logic det
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S01  = 3'd3,
        S10  = 3'd4,
        S010 = 3'd5,
        S101 = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; the spare encoding falls back to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (ser_in) state_d = S1;
                else        state_d = S0;
            end
            S0: begin
                if (ser_in) state_d = S01;
                else        state_d = S0;
            end
            S1: begin
                if (ser_in) state_d = S1;
                else        state_d = S10;
            end
            S01: begin
                if (ser_in) state_d = S1;
                else        state_d = S010;
            end
            S10: begin
                if (ser_in) state_d = S101;
                else        state_d = S0;
            end
            S010: begin
                if (ser_in) state_d = S101;
                else        state_d = S0;
            end
            S101: begin
                if (ser_in) state_d = S1;
                else        state_d = S010;
            end
            default: state_d = IDLE;
        endcase
    end

    // output decode from the state register only, so ser_in never reaches det
    always_comb begin
        det = 1'b0;
        case (state_q)
            S010:    det = 1'b1;
            S101:    det = 1'b1;
            default: det = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fsm_bin_palin_det.sv
// Directed bench for fsm_bin_palin_det: each step drives one bit (and rst) at the
// falling edge, then checks det just after the following rising edge.
module tb_fsm_bin_palin_det;

    logic clk;
    logic rst;
    logic ser_in;
    logic det;

    int checks;
    int errors;

    fsm_bin_palin_det dut (
        .ser_in (ser_in),
        .clk    (clk),
        .rst    (rst),
        .det    (det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic b, input logic exp, input string tag);
        @(negedge clk);
        rst    = r;
        ser_in = b;
        @(posedge clk);
        #1;
        checks++;
        assert (det === exp) else begin
            errors++;
            $error("FAIL %s: observed det=%b expected det=%b", tag, det, exp);
        end
    endtask

    task automatic bit_step(input logic b, input logic exp, input string tag);
        step(1'b0, b, exp, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        ser_in = 1'b0;

        // 1. reset for two edges with ser_in toggling, then first two bits
        step(1'b1, 1'b1, 1'b0, "reset_edge1");
        step(1'b1, 1'b0, 1'b0, "reset_edge2");
        bit_step(1'b1, 1'b0, "post_reset_bit1");
        bit_step(1'b0, 1'b0, "post_reset_bit2");

        // 2. basic 101 then 010
        do_reset("basic_reset_a");
        bit_step(1'b1, 1'b0, "b101_1");
        bit_step(1'b0, 1'b0, "b101_2");
        bit_step(1'b1, 1'b1, "b101_3");
        do_reset("basic_reset_b");
        bit_step(1'b0, 1'b0, "b010_1");
        bit_step(1'b1, 1'b0, "b010_2");
        bit_step(1'b0, 1'b1, "b010_3");

        // 3. mixed stream: det only after bits 8, 9 and 18
        do_reset("mixed_reset");
        bit_step(1'b1, 1'b0, "mix_01");
        bit_step(1'b0, 1'b0, "mix_02");
        bit_step(1'b0, 1'b0, "mix_03");
        bit_step(1'b1, 1'b0, "mix_04");
        bit_step(1'b1, 1'b0, "mix_05");
        bit_step(1'b1, 1'b0, "mix_06");
        bit_step(1'b0, 1'b0, "mix_07");
        bit_step(1'b1, 1'b1, "mix_08");
        bit_step(1'b0, 1'b1, "mix_09");
        bit_step(1'b0, 1'b0, "mix_10");
        bit_step(1'b1, 1'b0, "mix_11");
        bit_step(1'b1, 1'b0, "mix_12");
        bit_step(1'b1, 1'b0, "mix_13");
        bit_step(1'b1, 1'b0, "mix_14");
        bit_step(1'b0, 1'b0, "mix_15");
        bit_step(1'b0, 1'b0, "mix_16");
        bit_step(1'b1, 1'b0, "mix_17");
        bit_step(1'b0, 1'b1, "mix_18");
        bit_step(1'b0, 1'b0, "mix_19");

        // 4. overlapping alternating stream, then a repeated 1 breaks it
        do_reset("overlap_reset");
        bit_step(1'b0, 1'b0, "ovl_1");
        bit_step(1'b1, 1'b0, "ovl_2");
        bit_step(1'b0, 1'b1, "ovl_3");
        bit_step(1'b1, 1'b1, "ovl_4");
        bit_step(1'b0, 1'b1, "ovl_5");
        bit_step(1'b1, 1'b1, "ovl_6");
        bit_step(1'b1, 1'b0, "ovl_break");

        // 5. trivial palindromes never reported
        do_reset("trivial_reset");
        bit_step(1'b0, 1'b0, "zeros_1");
        bit_step(1'b0, 1'b0, "zeros_2");
        bit_step(1'b0, 1'b0, "zeros_3");
        bit_step(1'b0, 1'b0, "zeros_4");
        bit_step(1'b1, 1'b0, "ones_1");
        bit_step(1'b1, 1'b0, "ones_2");
        bit_step(1'b1, 1'b0, "ones_3");
        bit_step(1'b1, 1'b0, "ones_4");

        // 6. reset mid-pattern discards the prefix
        do_reset("mid_reset_pre");
        bit_step(1'b1, 1'b0, "mid_1");
        bit_step(1'b0, 1'b0, "mid_2");
        step(1'b1, 1'b1, 1'b0, "mid_rst");
        bit_step(1'b0, 1'b0, "mid_3");
        bit_step(1'b1, 1'b0, "mid_4");
        bit_step(1'b0, 1'b1, "mid_5");

        // reset while det is high clears it
        step(1'b1, 1'b0, 1'b0, "reset_while_det");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
